// File: rtl/mips_instr_encoder_if.sv
// Request and instruction-memory write bundle for mips_instr_encoder.
// The slave side is the encoder; the master side is the requester and the memory model.
interface mips_instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              im_req;
  logic              im_ack;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, im_ack,
    input  in_ready, im_req, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, im_ack,
    output in_ready, im_req, im_addr, im_wdata
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS instruction requests into machine words and writes them to
// consecutive IMEM word addresses through a one-entry buffered request/acknowledge port.
module mips_instr_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  mips_instr_encoder_if.slave bus,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              err,
  output logic [4:0]        err_mnem
);

  localparam logic [4:0] MnAddu = 5'd0;
  localparam logic [4:0] MnSubu = 5'd1;
  localparam logic [4:0] MnAdd  = 5'd2;
  localparam logic [4:0] MnSub  = 5'd3;
  localparam logic [4:0] MnAnd  = 5'd4;
  localparam logic [4:0] MnOr   = 5'd5;
  localparam logic [4:0] MnSlt  = 5'd6;
  localparam logic [4:0] MnSll  = 5'd7;
  localparam logic [4:0] MnSrl  = 5'd8;
  localparam logic [4:0] MnSra  = 5'd9;
  localparam logic [4:0] MnJr   = 5'd10;
  localparam logic [4:0] MnLui  = 5'd11;
  localparam logic [4:0] MnAddi = 5'd12;
  localparam logic [4:0] MnOri  = 5'd13;
  localparam logic [4:0] MnSlti = 5'd14;
  localparam logic [4:0] MnSw   = 5'd15;
  localparam logic [4:0] MnLw   = 5'd16;
  localparam logic [4:0] MnBeq  = 5'd17;
  localparam logic [4:0] MnBne  = 5'd18;
  localparam logic [4:0] MnJ    = 5'd19;
  localparam logic [4:0] MnJal  = 5'd20;

  localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {KindR, KindI, KindJ} kind_e;
  typedef enum logic [0:0] {StEmpty, StPend} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [4:0]        err_mnem_q;

  kind_e       kind;
  logic [5:0]  code;
  logic        legal;
  logic        is_shift;
  logic        is_jr;
  logic        is_lui;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  sh_f;
  logic [31:0] word;
  logic        accept;

  // Opcode (I/J-type) or funct (R-type) per mnemonic; anything above JAL is illegal.
  always_comb begin
    kind  = KindR;
    code  = 6'b000000;
    legal = 1'b1;
    case (bus.in_mnem)
      MnAddu: code = 6'b100001;
      MnSubu: code = 6'b100011;
      MnAdd:  code = 6'b100000;
      MnSub:  code = 6'b100010;
      MnAnd:  code = 6'b100100;
      MnOr:   code = 6'b100101;
      MnSlt:  code = 6'b101010;
      MnSll:  code = 6'b000000;
      MnSrl:  code = 6'b000010;
      MnSra:  code = 6'b000011;
      MnJr:   code = 6'b001000;
      MnLui:  begin kind = KindI; code = 6'b001111; end
      MnAddi: begin kind = KindI; code = 6'b001000; end
      MnOri:  begin kind = KindI; code = 6'b001101; end
      MnSlti: begin kind = KindI; code = 6'b001010; end
      MnSw:   begin kind = KindI; code = 6'b101011; end
      MnLw:   begin kind = KindI; code = 6'b100011; end
      MnBeq:  begin kind = KindI; code = 6'b000100; end
      MnBne:  begin kind = KindI; code = 6'b000101; end
      MnJ:    begin kind = KindJ; code = 6'b000010; end
      MnJal:  begin kind = KindJ; code = 6'b000011; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    is_shift = (bus.in_mnem == MnSll) || (bus.in_mnem == MnSrl) || (bus.in_mnem == MnSra);
    is_jr    = (bus.in_mnem == MnJr);
    is_lui   = (bus.in_mnem == MnLui);
    rs_f     = (is_shift || is_lui) ? 5'd0 : bus.in_rs;
    rt_f     = is_jr ? 5'd0 : bus.in_rt;
    rd_f     = is_jr ? 5'd0 : bus.in_rd;
    sh_f     = is_shift ? bus.in_shamt : 5'd0;
    word     = 32'd0;
    case (kind)
      KindR:   word = {6'b000000, rs_f, rt_f, rd_f, sh_f, code};
      KindI:   word = {code, rs_f, rt_f, bus.in_imm};
      KindJ:   word = {code, bus.in_target};
      default: word = 32'd0;
    endcase
  end

  // in_ready passes im_ack straight through so a stalled word and its successor can swap
  // in the same cycle.
  assign full         = ptr_q[ADDR_W];
  assign bus.in_ready = !full && ((state_q == StEmpty) || bus.im_ack);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      state_q    <= StEmpty;
      ptr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_mnem_q <= 5'd0;
    end else begin
      if (accept && legal) begin
        state_q <= StPend;
        addr_q  <= ptr_q[ADDR_W-1:0];
        wdata_q <= word;
        ptr_q   <= ptr_q + PtrOne;
      end else if ((state_q == StPend) && bus.im_ack) begin
        state_q <= StEmpty;
      end
      if (accept && !legal) begin
        err_q <= 1'b1;
        if (!err_q) begin
          err_mnem_q <= bus.in_mnem;
        end
      end
    end
  end

  assign bus.im_req   = (state_q == StPend);
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign wr_count     = ptr_q;
  assign err          = err_q;
  assign err_mnem     = err_mnem_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with a 4-word IMEM so capacity limits are reachable.
module tb_mips_instr_encoder;

  localparam int unsigned ADDR_W = 2;

  logic            clk;
  logic            rstn;
  logic            clr;
  logic [ADDR_W:0] wr_count;
  logic            full;
  logic            err;
  logic [4:0]      err_mnem;

  int n_checks;
  int n_pass;

  mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  mips_instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .bus      (bus),
    .wr_count (wr_count),
    .full     (full),
    .err      (err),
    .err_mnem (err_mnem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_mnem   = 5'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_shamt  = 5'd0;
    bus.in_imm    = 16'd0;
    bus.in_target = 26'd0;
  endtask

  task automatic send(input logic [4:0] mnem, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [15:0] imm,
                      input logic [25:0] target);
    bus.in_valid  = 1'b1;
    bus.in_mnem   = mnem;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_shamt  = shamt;
    bus.in_imm    = imm;
    bus.in_target = target;
  endtask

  task automatic restart();
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rstn       = 1'b0;
    clr        = 1'b0;
    bus.im_ack = 1'b0;
    idle();
    step();
    step();
    rstn = 1'b1;
    #1;
    check_eq("rst in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst im_req", 32'(bus.im_req), 32'd0);
    check_eq("rst im_addr", 32'(bus.im_addr), 32'd0);
    check_eq("rst im_wdata", bus.im_wdata, 32'd0);
    check_eq("rst wr_count", 32'(wr_count), 32'd0);
    check_eq("rst full", 32'(full), 32'd0);
    check_eq("rst err", 32'(err), 32'd0);
    check_eq("rst err_mnem", 32'(err_mnem), 32'd0);

    // Single ADDI
    bus.im_ack = 1'b1;
    send(5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0);
    step();
    idle();
    check_eq("addi req", 32'(bus.im_req), 32'd1);
    check_eq("addi word", bus.im_wdata, 32'h2022_0005);
    check_eq("addi addr", 32'(bus.im_addr), 32'd0);
    check_eq("addi count", 32'(wr_count), 32'd1);
    step();
    check_eq("addi drained", 32'(bus.im_req), 32'd0);
    restart();
    check_eq("clr count", 32'(wr_count), 32'd0);

    // Back-to-back ADDU, JAL, J with ack held high
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    step();
    check_eq("b2b0 req", 32'(bus.im_req), 32'd1);
    check_eq("b2b0 word", bus.im_wdata, 32'h0022_1821);
    check_eq("b2b0 addr", 32'(bus.im_addr), 32'd0);
    send(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
    step();
    check_eq("b2b1 req", 32'(bus.im_req), 32'd1);
    check_eq("b2b1 word", bus.im_wdata, 32'h0C00_0010);
    check_eq("b2b1 addr", 32'(bus.im_addr), 32'd1);
    send(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
    step();
    idle();
    check_eq("b2b2 req", 32'(bus.im_req), 32'd1);
    check_eq("b2b2 word", bus.im_wdata, 32'h0800_0010);
    check_eq("b2b2 addr", 32'(bus.im_addr), 32'd2);
    check_eq("b2b count", 32'(wr_count), 32'd3);
    step();
    check_eq("b2b drained", 32'(bus.im_req), 32'd0);
    restart();

    // Field forcing: SLL drops rs, LUI drops rs
    send(5'd7, 5'd7, 5'd2, 5'd4, 5'd3, 16'hFFFF, 26'd0);
    step();
    check_eq("sll word", bus.im_wdata, 32'h0002_20C0);
    send(5'd11, 5'd5, 5'd1, 5'd9, 5'd9, 16'h1234, 26'd0);
    step();
    check_eq("lui word", bus.im_wdata, 32'h3C01_1234);
    send(5'd10, 5'd31, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0);
    step();
    idle();
    check_eq("jr word", bus.im_wdata, 32'h03E0_0008);
    restart();

    // Stall with the next request waiting
    bus.im_ack = 1'b0;
    send(5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0);
    step();
    send(5'd13, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 26'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("stall ready", 32'(bus.in_ready), 32'd0);
      check_eq("stall req", 32'(bus.im_req), 32'd1);
      check_eq("stall word", bus.im_wdata, 32'h2022_0005);
      check_eq("stall addr", 32'(bus.im_addr), 32'd0);
      step();
    end
    bus.im_ack = 1'b1;
    #1;
    check_eq("unstall ready", 32'(bus.in_ready), 32'd1);
    step();
    idle();
    check_eq("unstall word", bus.im_wdata, 32'h3464_00FF);
    check_eq("unstall addr", 32'(bus.im_addr), 32'd1);
    check_eq("unstall count", 32'(wr_count), 32'd2);
    restart();

    // Illegal mnemonics then a legal ADD
    send(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    #1;
    check_eq("ill ready", 32'(bus.in_ready), 32'd1);
    step();
    send(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    step();
    check_eq("ill err", 32'(err), 32'd1);
    check_eq("ill mnem", 32'(err_mnem), 32'd25);
    check_eq("ill req", 32'(bus.im_req), 32'd0);
    check_eq("ill count", 32'(wr_count), 32'd0);
    send(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    step();
    idle();
    check_eq("add word", bus.im_wdata, 32'h0022_1820);
    check_eq("add addr", 32'(bus.im_addr), 32'd0);
    check_eq("add count", 32'(wr_count), 32'd1);
    check_eq("add err kept", 32'(err_mnem), 32'd25);
    restart();
    check_eq("clr err", 32'(err), 32'd0);
    check_eq("clr err_mnem", 32'(err_mnem), 32'd0);

    // Capacity of 4 words, then clr while a word is pending
    for (int i = 0; i < 4; i++) begin
      send(5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 16'(i), 26'd0);
      step();
    end
    #1;
    check_eq("cap full", 32'(full), 32'd1);
    check_eq("cap ready", 32'(bus.in_ready), 32'd0);
    check_eq("cap count", 32'(wr_count), 32'd4);
    check_eq("cap addr", 32'(bus.im_addr), 32'd3);
    check_eq("cap word", bus.im_wdata, 32'h2000_0003);
    bus.im_ack = 1'b0;
    step();
    check_eq("cap hold req", 32'(bus.im_req), 32'd1);
    check_eq("cap hold count", 32'(wr_count), 32'd4);
    bus.im_ack = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    idle();
    check_eq("clr req", 32'(bus.im_req), 32'd0);
    check_eq("clr count2", 32'(wr_count), 32'd0);
    check_eq("clr full", 32'(full), 32'd0);
    check_eq("clr ready", 32'(bus.in_ready), 32'd1);
    check_eq("clr addr", 32'(bus.im_addr), 32'd0);
    check_eq("clr wdata", bus.im_wdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Loader-side block that turns symbolic instruction requests into 32-bit MIPS machine words. It writes them to consecutive instruction-memory word addresses through a stall-able request/acknowledge port. It covers the instruction subset the pipeline's control decoder supports and is used by test harnesses and the boot loader to fill IMEM before the core is released from reset. Encoding is registered in a one-entry output buffer, so throughput is one word per cycle when memory acknowledges immediately.

## Interface
- ADDR_W, 10, IMEM word-address width; capacity 2^ADDR_W words
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- clr  in  1  synchronous restart: same effect as reset, lower priority than rstn
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept this cycle
- in_mnem  in  5  mnemonic code (see Operation)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- im_req  out  1  buffered word valid, write requested
- im_ack  in  1  memory accepted the word this cycle
- im_addr  out  ADDR_W  word address of buffered word
- im_wdata  out  32  encoded instruction
- wr_count  out  ADDR_W+1  words accepted for writing since reset/clr
- full  out  1  wr_count == 2^ADDR_W
- err  out  1  sticky: an illegal mnemonic was received
- err_mnem  out  5  first illegal mnemonic received

## Operation
- Mnemonic codes: 0 ADDU, 1 SUBU, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 SLT, 7 SLL, 8 SRL, 9 SRA, 10 JR, 11 LUI, 12 ADDI, 13 ORI, 14 SLTI, 15 SW, 16 LW, 17 BEQ, 18 BNE, 19 J, 20 JAL. Codes 21–31 are illegal.
- R-type (0–10): {6'b000000, rs, rt, rd, shamt, funct}. funct values:
  - ADDU 100001, SUBU 100011, ADD 100000, SUB 100010
  - AND 100100, OR 100101, SLT 101010
  - SLL 000000, SRL 000010, SRA 000011, JR 001000
- R-type field forcing:
  - shamt is forced to 0 except for SLL/SRL/SRA.
  - rs is forced to 0 for SLL/SRL/SRA.
  - rt, rd and shamt are forced to 0 for JR.
- I-type: {op, rs, rt, imm}. op values: LUI 001111 (rs forced 0), ADDI 001000, ORI 001101, SLTI 001010, SW 101011, LW 100011, BEQ 000100, BNE 000101.
- J-type: {op, target}. op values: J 000010, JAL 000011.
- Buffer FSM:
  - EMPTY (im_req=0): on accept of a legal request, load the word and go to PEND.
  - PEND (im_req=1): im_addr and im_wdata are held stable until im_ack.
  - On im_ack with a simultaneous legal accept, stay in PEND with the new word; otherwise go to EMPTY.
- Write pointer:
  - Starts at 0 and increments by 1 on each legal accept; im_addr takes the pointer value at accept.
  - wr_count equals the pointer.
  - There is no wrap-around: at 2^ADDR_W, full=1 and in_ready=0 until clr or reset.
- in_ready = !full && (state==EMPTY || im_ack). This is a combinational pass-through on im_ack.
- Illegal mnemonic:
  - The handshake completes; nothing is buffered and the pointer is unchanged.
  - err is set; err_mnem captures the code only if err was 0.
- Accepts while full are impossible because in_ready=0. in_valid without in_ready has no effect.
- Reset/clr in any state:
  - Buffer goes to EMPTY, pointer to 0, err cleared.
  - A pending word is discarded, even if im_ack is high that cycle.

## Timing
- Reset values: in_ready=1, im_req=0, im_addr=0, im_wdata=0, wr_count=0, full=0, err=0, err_mnem=0.
- Latency: accept on edge N; im_req=1 with valid data from after edge N (visible in cycle N+1).
- With im_ack tied high: one word per cycle, consecutive addresses.
- im_ack while im_req=0 is ignored.
- full asserts the cycle after the 2^ADDR_W-th legal accept. The last word still completes its im_req/im_ack handshake after full asserts.
- rstn and clr take effect at the next rising edge; all outputs show reset values the following cycle.

## Test plan
- ADDI rs=1 rt=2 imm=0x0005, ack high → im_wdata=0x20220005 at im_addr 0; wr_count=1.
- Back-to-back requests with ack high:
  - ADDU rs=1 rt=2 rd=3 → 0x00221821 at addr 0.
  - JAL target=0x10 → 0x0C000010 at addr 1.
  - J target=0x10 → 0x08000010 at addr 2.
  - im_req stays high for 3 consecutive cycles.
- Field forcing: SLL rs=7 rt=2 rd=4 shamt=3 → 0x000220C0; LUI rs=5 rt=1 imm=0x1234 → 0x3C011234.
- Stall: hold im_ack=0 for 4 cycles with the next request waiting → word and address stable, in_ready=0; on im_ack=1 the next word loads the same cycle.
- Illegal: mnem=25, then mnem=30, then ADD → err=1, err_mnem=25, ADD written at addr 0, wr_count=1.
- Capacity/restart with ADDR_W=2: 4 legal accepts → full=1, in_ready=0. Then clr during PEND → im_req=0, wr_count=0, full=0 next cycle.
